mode_register: RTL and testbench
================================

MODE_REGISTER -- requirements
Module: mode_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data/register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, value loaded into out on reset (WIDTH bits).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 en  input  1  operation enable; 0 forces HOLD regardless of op.
REQ-006 op  input  3  operation select, encoding per REQ-010.
REQ-007 data  input  WIDTH  parallel load value.
REQ-008 ser_in  input  1  serial fill bit for SHL/SHR.
REQ-009 out  output  WIDTH  registered value; carry  output  1  registered carry/borrow/shift-out flag; zero  output  1  combinational, 1 iff out == 0.

Function
REQ-010 op encoding SHALL be: 000 HOLD, 001 LOAD, 010 CLEAR, 011 INC, 100 DEC, 101 SHL, 110 SHR, 111 ROR.
REQ-011 All updates to out and carry SHALL occur on the rising clk edge following the qualifying inputs; latency one cycle, no combinational path from data/op to out or carry.
REQ-012 HOLD (or en=0): out and carry SHALL retain their values.
REQ-013 LOAD: out <= data; carry <= 0.
REQ-014 CLEAR: out <= 0; carry <= 0.
REQ-015 INC: out <= out + 1 modulo 2^WIDTH; carry <= 1 iff out was all-ones (wrap to 0), else 0.
REQ-016 DEC: out <= out - 1 modulo 2^WIDTH; carry <= 1 iff out was 0 (wrap to all-ones, borrow), else 0.
REQ-017 SHL: out <= {out[WIDTH-2:0], ser_in}; carry <= old out[WIDTH-1].
REQ-018 SHR: out <= {ser_in, out[WIDTH-1:1]}; carry <= old out[0].
REQ-019 ROR: out <= {out[0], out[WIDTH-1:1]}; carry <= old out[0]; ser_in ignored.
REQ-020 data SHALL be ignored for every op other than LOAD; ser_in SHALL be ignored for every op other than SHL/SHR.
REQ-021 zero SHALL track out combinationally in the same cycle out changes; carry SHALL NOT affect zero.
REQ-022 Back-to-back ops on consecutive cycles SHALL each operate on the value produced by the previous cycle, with no bubbles.
REQ-023 The block SHALL contain no X-propagating state: every op code, including with en=0, SHALL yield defined out/carry.

Reset
REQ-024 When rst=1 at a rising edge, out SHALL become RESET_VALUE and carry 0, regardless of en, op, data, ser_in.
REQ-025 rst SHALL take priority over any op in the same cycle; an op asserted with rst SHALL have no effect.
REQ-026 After rst deasserts, the first op SHALL act on RESET_VALUE with carry 0; zero SHALL equal (RESET_VALUE == 0) immediately after reset.
REQ-027 Reset asserted mid-sequence (e.g. during consecutive INCs) SHALL abort the sequence with no residual effect on the next post-reset cycle.

Verification (WIDTH=8, RESET_VALUE=0 unless stated)
REQ-028 rst=1 one cycle with en=1, op=LOAD, data=8'hA5 -> out=8'h00, carry=0, zero=1; same with RESET_VALUE=8'h3C -> out=8'h3C, zero=0.
REQ-029 LOAD 8'hFE, then INC, INC, INC -> out 8'hFF carry 0; out 8'h00 carry 1 zero 1; out 8'h01 carry 0.
REQ-030 LOAD 8'h01, then DEC, DEC -> out 8'h00 carry 0 zero 1; out 8'hFF carry 1; then en=0 with op=CLEAR for 3 cycles -> out 8'hFF, carry 1 unchanged.
REQ-031 LOAD 8'h81, SHL ser_in=0 -> out 8'h02 carry 1; SHR ser_in=1 -> out 8'h81 carry 0; ROR -> out 8'hC0 carry 1.
REQ-032 LOAD 8'h10, INC x3 with rst=1 on the 2nd INC cycle -> out 8'h11, then 8'h00 carry 0, then 8'h01 (third INC acts on reset value).
REQ-033 Randomised op/en/data/ser_in stream for 10k cycles at WIDTH 2, 8, 32 SHALL match a cycle-accurate reference model on out, carry, zero every cycle.

Source files
------------

// File: rtl/mode_register.sv
// Single-register datapath: load/clear/inc/dec/shift/rotate with a registered
// carry/borrow/shift-out flag and a combinational zero flag.
module mode_register #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_CLEAR = 3'b010,
    OP_INC   = 3'b011,
    OP_DEC   = 3'b100,
    OP_SHL   = 3'b101,
    OP_SHR   = 3'b110,
    OP_ROR   = 3'b111
  } op_e;

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic [WIDTH-1:0] w_next_out;
  logic             w_next_carry;
  op_e              w_op;

  assign w_op = op_e'(op);

  always_comb begin
    w_next_out   = r_out;
    w_next_carry = r_carry;
    if (en) begin
      unique case (w_op)
        OP_HOLD: begin
          w_next_out   = r_out;
          w_next_carry = r_carry;
        end
        OP_LOAD: begin
          w_next_out   = data;
          w_next_carry = 1'b0;
        end
        OP_CLEAR: begin
          w_next_out   = '0;
          w_next_carry = 1'b0;
        end
        OP_INC: begin
          w_next_out   = r_out + 1'b1;
          w_next_carry = (r_out == '1);
        end
        OP_DEC: begin
          w_next_out   = r_out - 1'b1;
          w_next_carry = (r_out == '0);
        end
        OP_SHL: begin
          w_next_out   = {r_out[WIDTH-2:0], ser_in};
          w_next_carry = r_out[WIDTH-1];
        end
        OP_SHR: begin
          w_next_out   = {ser_in, r_out[WIDTH-1:1]};
          w_next_carry = r_out[0];
        end
        OP_ROR: begin
          w_next_out   = {r_out[0], r_out[WIDTH-1:1]};
          w_next_carry = r_out[0];
        end
        default: begin
          w_next_out   = r_out;
          w_next_carry = r_carry;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= RESET_VALUE;
      r_carry <= 1'b0;
    end else begin
      r_out   <= w_next_out;
      r_carry <= w_next_carry;
    end
  end

  assign out   = r_out;
  assign carry = r_carry;
  assign zero  = (r_out == '0);

endmodule

// File: tb/tb_mode_register.sv
// Four mode_register instances (widths 8/8/2/32) share one stimulus stream and
// are checked every cycle against an arithmetic reference model.
module tb_mode_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [31:0] data;
  logic        ser_in;

  logic [7:0]  o0, o1;
  logic [1:0]  o2;
  logic [31:0] o3;
  logic        c0, c1, c2, c3;
  logic        z0, z1, z2, z3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mode_register #(.WIDTH(8), .RESET_VALUE(8'h00)) u0 (
    .clk(clk), .rst(rst), .en(en), .op(op), .data(data[7:0]), .ser_in(ser_in),
    .out(o0), .carry(c0), .zero(z0));
  mode_register #(.WIDTH(8), .RESET_VALUE(8'h3C)) u1 (
    .clk(clk), .rst(rst), .en(en), .op(op), .data(data[7:0]), .ser_in(ser_in),
    .out(o1), .carry(c1), .zero(z1));
  mode_register #(.WIDTH(2), .RESET_VALUE(2'b10)) u2 (
    .clk(clk), .rst(rst), .en(en), .op(op), .data(data[1:0]), .ser_in(ser_in),
    .out(o2), .carry(c2), .zero(z2));
  mode_register #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) u3 (
    .clk(clk), .rst(rst), .en(en), .op(op), .data(data), .ser_in(ser_in),
    .out(o3), .carry(c3), .zero(z3));

  // Reference model: values held as plain integers, updated from the op rules.
  int unsigned      W  [4] = '{8, 8, 2, 32};
  longint unsigned  RV [4] = '{64'h00, 64'h3C, 64'h2, 64'hDEADBEEF};
  longint unsigned  m_out [4];
  bit               m_car [4];
  bit               m_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      longint unsigned mask, v;
      bit c;
      mask = (64'd1 << W[i]) - 64'd1;
      v = m_out[i];
      c = m_car[i];
      if (rst) begin
        v = RV[i];
        c = 1'b0;
      end else if (en) begin
        case (op)
          3'd1: begin v = longint'(data) & mask; c = 1'b0; end
          3'd2: begin v = 0; c = 1'b0; end
          3'd3: begin c = (v == mask); v = (v + 1) & mask; end
          3'd4: begin c = (v == 0); v = (v + mask) & mask; end
          3'd5: begin c = v[W[i]-1]; v = ((v << 1) | longint'(ser_in)) & mask; end
          3'd6: begin c = v[0]; v = (v >> 1) | (longint'(ser_in) << (W[i]-1)); end
          3'd7: begin c = v[0]; v = (v >> 1) | ((v & 1) << (W[i]-1)); end
          default: ;
        endcase
      end
      m_out[i] = v;
      m_car[i] = c;
    end
    if (rst) m_valid = 1'b1;
  end

  function automatic longint unsigned dut_out(int i);
    case (i)
      0: return longint'(o0);
      1: return longint'(o1);
      2: return longint'(o2);
      default: return longint'(o3);
    endcase
  endfunction

  function automatic bit dut_bit(int i, bit want_zero);
    case (i)
      0: return want_zero ? z0 : c0;
      1: return want_zero ? z1 : c1;
      2: return want_zero ? z2 : c2;
      default: return want_zero ? z3 : c3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 4; i++) begin
        bit m_zero;
        m_zero = (m_out[i] == 0);
        n_checks++;
        if (dut_out(i) === m_out[i] && dut_bit(i, 1'b0) === m_car[i] &&
            dut_bit(i, 1'b1) === m_zero)
          n_pass++;
        else
          $display("FAIL model_u%0d t=%0t got out=%h carry=%b zero=%b want out=%h carry=%b zero=%b",
                   i, $time, dut_out(i), dut_bit(i, 1'b0), dut_bit(i, 1'b1),
                   m_out[i], m_car[i], m_zero);
      end
    end
  end

  task automatic step(input bit r, input bit e, input logic [2:0] o,
                      input logic [31:0] d, input bit s);
    rst = r; en = e; op = o; data = d; ser_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [9:0] got, input logic [9:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got {carry,zero,out}=%h want %h", name, got, want);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = 3'd0; data = '0; ser_in = 1'b0;
    @(posedge clk); #1;

    step(1, 1, 3'd1, 32'hA5, 0);
    lit("rst_rv00", {c0, z0, o0}, {1'b0, 1'b1, 8'h00});
    lit("rst_rv3c", {c1, z1, o1}, {1'b0, 1'b0, 8'h3C});

    step(0, 1, 3'd1, 32'hFE, 0); lit("load_fe", {c0, z0, o0}, {2'b00, 8'hFE});
    step(0, 1, 3'd3, 32'h0, 0);  lit("inc_ff",  {c0, z0, o0}, {2'b00, 8'hFF});
    step(0, 1, 3'd3, 32'h0, 0);  lit("inc_wrap", {c0, z0, o0}, {2'b11, 8'h00});
    step(0, 1, 3'd3, 32'h0, 0);  lit("inc_01",  {c0, z0, o0}, {2'b00, 8'h01});

    step(0, 1, 3'd1, 32'h01, 0); lit("load_01", {c0, z0, o0}, {2'b00, 8'h01});
    step(0, 1, 3'd4, 32'h0, 0);  lit("dec_00",  {c0, z0, o0}, {2'b01, 8'h00});
    step(0, 1, 3'd4, 32'h0, 0);  lit("dec_borrow", {c0, z0, o0}, {2'b10, 8'hFF});
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 3'd2, 32'h0, 0);
      lit("en0_hold", {c0, z0, o0}, {2'b10, 8'hFF});
    end

    step(0, 1, 3'd1, 32'h81, 0); lit("load_81", {c0, z0, o0}, {2'b00, 8'h81});
    step(0, 1, 3'd5, 32'hFF, 0); lit("shl",     {c0, z0, o0}, {2'b10, 8'h02});
    step(0, 1, 3'd6, 32'hFF, 1); lit("shr",     {c0, z0, o0}, {2'b00, 8'h81});
    step(0, 1, 3'd7, 32'hFF, 0); lit("ror",     {c0, z0, o0}, {2'b10, 8'hC0});

    step(0, 1, 3'd1, 32'h10, 0); lit("load_10", {c0, z0, o0}, {2'b00, 8'h10});
    step(0, 1, 3'd3, 32'h0, 0);  lit("inc_11",  {c0, z0, o0}, {2'b00, 8'h11});
    step(1, 1, 3'd3, 32'h0, 0);  lit("inc_rst", {c0, z0, o0}, {2'b01, 8'h00});
    step(0, 1, 3'd3, 32'h0, 0);  lit("inc_post_rst", {c0, z0, o0}, {2'b00, 8'h01});

    for (int n = 0; n < 10000; n++) begin
      step(($urandom % 64) == 0, ($urandom % 4) != 0, 3'($urandom % 8),
           $urandom, 1'($urandom % 2));
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
